// File: rtl/mic_frontend_if.sv
// Bus bundle between the mic front end and its consumers: raw triggers and
// clear in, qualified hits, arrival order and window status out.
interface mic_frontend_if;
  logic [3:0] mic;
  logic       clear;
  logic [3:0] hits;
  logic [1:0] first_ch;
  logic [7:0] order;
  logic       done;
  logic       timeout;

  modport master (
    output mic, clear,
    input  hits, first_ch, order, done, timeout
  );

  modport slave (
    input  mic, clear,
    output hits, first_ch, order, done, timeout
  );
endinterface

// File: rtl/mic_frontend.sv
// Synchronises, glitch-filters and ranks the four mic triggers, then holds the
// capture result until clear. Arrival-order tracking is built only with MICFE_ORDER_EN.
//
// state   | meaning
// IDLE    | armed, no hit yet in this window
// CAPTURE | first hit seen, timer running, collecting remaining hits
// DONE    | window closed (all four hits or timeout); results frozen
module mic_frontend #(
  parameter int FILT_LEN = 4,
  parameter int TO_WIDTH = 16,
  parameter int TIMEOUT  = 40000
) (
  input  logic           clk,
  input  logic           ares,
  mic_frontend_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [3:0]          FILT_MAX = 4'(FILT_LEN);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          filt_q [4];
  logic [3:0]          filt_d [4];
  logic [3:0]          armed_q, armed_d;
  logic [3:0]          hits_q, hits_d;
  logic [1:0]          first_ch_q, first_ch_d;
  logic [TO_WIDTH-1:0] timer_q, timer_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [3:0]          qual, new_hits;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    casez (v)
      4'b???1: low_idx = 2'd0;
      4'b??10: low_idx = 2'd1;
      4'b?100: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  endfunction

  // A channel qualifies on the cycle its count reaches FILT_LEN, once per low-to-high episode.
  always_comb begin
    qual    = '0;
    armed_d = armed_q;
    for (int i = 0; i < 4; i++) begin
      if (!sync2_q[i])              filt_d[i] = '0;
      else if (filt_q[i] == FILT_MAX) filt_d[i] = filt_q[i];
      else                           filt_d[i] = filt_q[i] + 4'd1;
      qual[i] = armed_q[i] && (filt_d[i] == FILT_MAX);
      if (!sync2_q[i])              armed_d[i] = 1'b1;
      if (qual[i] || bus.clear)     armed_d[i] = 1'b0;
    end
  end

  assign new_hits = qual & ~hits_q;

  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    first_ch_d = first_ch_q;
    timer_d    = timer_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    if (bus.clear) begin
      state_d    = IDLE;
      hits_d     = '0;
      first_ch_d = '0;
      timer_d    = '0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|new_hits) begin
            hits_d     = new_hits;
            first_ch_d = low_idx(new_hits);
            timer_d    = '0;
            if (new_hits == 4'hF) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          hits_d  = hits_q | new_hits;
          timer_d = timer_q + 1'b1;
          if (hits_d == 4'hF) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (timer_q == TO_LAST) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      armed_q    <= 4'hF;
      hits_q     <= '0;
      first_ch_q <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      for (int i = 0; i < 4; i++) filt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= bus.mic;
      sync2_q    <= sync1_q;
      armed_q    <= armed_d;
      hits_q     <= hits_d;
      first_ch_q <= first_ch_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      for (int i = 0; i < 4; i++) filt_q[i] <= filt_d[i];
    end
  end

`ifdef MICFE_ORDER_EN
  logic [2:0] rank_q, rank_d;
  logic [7:0] order_q, order_d;

  // Same-cycle hits take consecutive ranks, lowest channel index first.
  always_comb begin
    rank_d  = rank_q;
    order_d = order_q;
    if (bus.clear) begin
      rank_d  = '0;
      order_d = '0;
    end else if (state_q != DONE) begin
      for (int i = 0; i < 4; i++) begin
        if (new_hits[i] && (rank_d < 3'd4)) begin
          order_d[{rank_d[1:0], 1'b0} +: 2] = 2'(i);
          rank_d = rank_d + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      rank_q  <= '0;
      order_q <= '0;
    end else begin
      rank_q  <= rank_d;
      order_q <= order_d;
    end
  end

  assign bus.order = order_q;
`else
  assign bus.order = 8'h00;
`endif

  assign bus.hits     = hits_q;
  assign bus.first_ch = first_ch_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mic_frontend.sv
// Directed bench for mic_frontend: step table of {mic, clear, cycles, expected
// outputs} plus hand sequences for latency, reset and async reset mid-capture.
module tb_mic_frontend;

`ifdef MICFE_ORDER_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  typedef struct {
    logic [3:0] mic;
    bit         clr;
    int         n;
    logic [3:0] hits;
    logic [1:0] first;
    logic [7:0] order;
    bit         done;
    bit         to;
  } step_t;

  logic clk;
  logic ares;
  int   total;
  int   bad;

  mic_frontend_if bus ();

  mic_frontend #(.FILT_LEN(4), .TO_WIDTH(16), .TIMEOUT(100)) dut (
    .clk  (clk),
    .ares (ares),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] h, input logic [1:0] f,
                           input logic [7:0] o, input bit d, input bit t);
    check({tag, " hits"},     {4'h0, bus.hits},     {4'h0, h});
    check({tag, " first_ch"}, {6'h0, bus.first_ch}, {6'h0, f});
    check({tag, " order"},    bus.order,            ORD ? o : 8'h00);
    check({tag, " done"},     {7'h0, bus.done},     {7'h0, d});
    check({tag, " timeout"},  {7'h0, bus.timeout},  {7'h0, t});
  endtask

  step_t tbl [20];

  initial begin
    total = 0;
    bad   = 0;

    //        mic     clr  n    hits    first order  done to
    tbl[0]  = '{4'b0001, 1'b0, 14, 4'b0001, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 1,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 5,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 1'b0, 3,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b0, 8,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{4'b1000, 1'b0, 6,  4'b1000, 2'd3, 8'h03, 1'b0, 1'b0};
    tbl[6]  = '{4'b1000, 1'b0, 4,  4'b1000, 2'd3, 8'h03, 1'b0, 1'b0};
    tbl[7]  = '{4'b1010, 1'b0, 6,  4'b1010, 2'd3, 8'h07, 1'b0, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 6,  4'b1111, 2'd3, 8'h87, 1'b1, 1'b0};
    tbl[9]  = '{4'b1111, 1'b0, 5,  4'b1111, 2'd3, 8'h87, 1'b1, 1'b0};
    tbl[10] = '{4'b0001, 1'b1, 1,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 10, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 3,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{4'b0001, 1'b0, 6,  4'b0001, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 3,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{4'b0010, 1'b0, 6,  4'b0010, 2'd1, 8'h01, 1'b0, 1'b0};
    tbl[16] = '{4'b0010, 1'b0, 99, 4'b0010, 2'd1, 8'h01, 1'b0, 1'b0};
    tbl[17] = '{4'b0011, 1'b0, 1,  4'b0010, 2'd1, 8'h01, 1'b1, 1'b1};
    tbl[18] = '{4'b0011, 1'b0, 10, 4'b0010, 2'd1, 8'h01, 1'b1, 1'b1};
    tbl[19] = '{4'b0000, 1'b1, 3,  4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};

    ares      = 1'b1;
    bus.mic   = 4'h0;
    bus.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 ares = 1'b0;
    check_all("reset", 4'h0, 2'd0, 8'h00, 1'b0, 1'b0);

    // North rises: 2 sync + 4 filter edges before the hit registers.
    bus.mic = 4'b0001;
    repeat (5) tick();
    check("latency edge5 hits", {4'h0, bus.hits}, 8'h00);
    tick();
    check_all("latency edge6", 4'b0001, 2'd0, 8'h00, 1'b0, 1'b0);

    for (int s = 0; s < 20; s++) begin
      bus.mic = tbl[s].mic;
      if (tbl[s].clr) begin
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (tbl[s].n - 1) tick();
      end else begin
        repeat (tbl[s].n) tick();
      end
      check_all($sformatf("step%0d", s), tbl[s].hits, tbl[s].first, tbl[s].order,
                tbl[s].done, tbl[s].to);
    end

    // Async reset in the middle of a capture window.
    bus.mic = 4'b0100;
    repeat (6) tick();
    check_all("east capture", 4'b0100, 2'd2, 8'h02, 1'b0, 1'b0);
    #2 ares = 1'b1;
    #1;
    check_all("ares async", 4'h0, 2'd0, 8'h00, 1'b0, 1'b0);
    #1 ares = 1'b0;
    repeat (2) tick();
    check_all("after ares", 4'h0, 2'd0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
